// File: rtl/ddrif_pkg.sv
// Shared types and header layout for the ddrif requester arbiter.
// Header word: WR at the MSB, LEN directly below it, ADDR from bit 0, zeros in between.
package ddrif_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StWdat,
        StRdat,
        StDone
    } arb_state_e;

    // Widest header the pack function supports; callers size-cast the result down.
    localparam int unsigned HDR_MAX_W    = 1024;
    localparam int unsigned HDR_ADDR_LSB = 0;

    function automatic int unsigned hdr_wr_bit(input int unsigned dw);
        return dw - 1;
    endfunction

    function automatic int unsigned hdr_len_lsb(input int unsigned dw, input int unsigned lw);
        return dw - 1 - lw;
    endfunction

    function automatic logic [HDR_MAX_W-1:0] hdr_pack(
        input int unsigned          dw,
        input int unsigned          lw,
        input int unsigned          aw,
        input logic                 wr,
        input logic [HDR_MAX_W-1:0] len,
        input logic [HDR_MAX_W-1:0] addr
    );
        logic [HDR_MAX_W-1:0] ones;
        logic [HDR_MAX_W-1:0] hdr;
        ones = '1;
        hdr  = (addr & (ones >> (HDR_MAX_W - aw))) << HDR_ADDR_LSB;
        hdr  = hdr | ((len & (ones >> (HDR_MAX_W - lw))) << hdr_len_lsb(dw, lw));
        hdr  = hdr | (HDR_MAX_W'(wr) << hdr_wr_bit(dw));
        return hdr;
    endfunction

endpackage

// File: rtl/ddrif_rr_arb.sv
// Combinational round-robin pick: the first set request after last_winner, wrapping at NREQ.
module ddrif_rr_arb
    import ddrif_pkg::*;
#(
    parameter  int unsigned NREQ = 3,
    localparam int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_winner,
    output logic [IW-1:0]   winner,
    output logic            valid
);

    logic [IW-1:0] cand;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        cand   = '0;
        for (int i = 1; i <= int'(NREQ); i++) begin
            cand = IW'((int'(last_winner) + i) % int'(NREQ));
            if (!valid && req[cand]) begin
                winner = cand;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddrif_arb.sv
// Arbitrates NREQ requesters onto one ddrif HZZ channel: header beat, then a write or read burst.
// One transaction at a time; grant is held from header through the last beat.
module ddrif_arb
    import ddrif_pkg::*;
#(
    parameter int unsigned NREQ   = 3,
    parameter int unsigned HZZ_DW = 256,
    parameter int unsigned APP_AW = 28,
    parameter int unsigned LW     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_wr,
    input  logic [NREQ*APP_AW-1:0]   req_addr,
    input  logic [NREQ*LW-1:0]       req_len,
    output logic [NREQ-1:0]          gnt,
    input  logic [NREQ*HZZ_DW-1:0]   wdata,
    input  logic [NREQ-1:0]          wvalid,
    output logic [NREQ-1:0]          wready,
    output logic [HZZ_DW-1:0]        rdata,
    output logic [NREQ-1:0]          rvalid,
    output logic [NREQ-1:0]          done,
    output logic [HZZ_DW-1:0]        hzz_mosi,
    output logic                     hzz_mosi_valid,
    input  logic                     hzz_mosi_en,
    input  logic [HZZ_DW-1:0]        hzz_miso,
    input  logic                     hzz_miso_valid
);

    localparam int unsigned IW = $clog2(NREQ);

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [IW-1:0]     last_q, last_d;
    logic              wr_q, wr_d;
    logic [APP_AW-1:0] addr_q, addr_d;
    logic [LW-1:0]     len_q, len_d;
    logic [LW:0]       cnt_q, cnt_d;
    logic              stray_rd, stray_d;

    logic [IW-1:0]     pick;
    logic              pick_vld;
    logic [NREQ-1:0]   sel;
    logic              last_beat;
    logic              w_fire;
    logic [HZZ_DW-1:0] hdr;

    ddrif_rr_arb #(
        .NREQ (NREQ)
    ) u_rr_arb (
        .req         (req),
        .last_winner (last_q),
        .winner      (pick),
        .valid       (pick_vld)
    );

    assign sel       = NREQ'(1) << idx_q;
    // Counter is one bit wider than len so a 2^LW-beat burst never wraps before it ends.
    assign last_beat = (cnt_q == {1'b0, len_q});
    assign w_fire    = wvalid[idx_q] & hzz_mosi_en;
    assign hdr       = HZZ_DW'(hdr_pack(HZZ_DW, LW, APP_AW, wr_q,
                                        HDR_MAX_W'(len_q), HDR_MAX_W'(addr_q)));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        // Read beats arriving outside a read burst are dropped but remembered.
        stray_d = stray_rd | (hzz_miso_valid && (state_q != StRdat));
        unique case (state_q)
            StIdle: begin
                if (pick_vld) begin
                    idx_d   = pick;
                    wr_d    = req_wr[pick];
                    addr_d  = req_addr[pick*APP_AW +: APP_AW];
                    len_d   = req_len[pick*LW +: LW];
                    cnt_d   = '0;
                    state_d = StHdr;
                end
            end
            StHdr: begin
                if (hzz_mosi_en) begin
                    state_d = wr_q ? StWdat : StRdat;
                end
            end
            StWdat: begin
                if (w_fire) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) begin
                        state_d = StDone;
                    end
                end
            end
            StRdat: begin
                if (hzz_miso_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                last_d  = idx_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        gnt            = '0;
        wready         = '0;
        rvalid         = '0;
        done           = '0;
        rdata          = '0;
        hzz_mosi       = '0;
        hzz_mosi_valid = 1'b0;
        unique case (state_q)
            StHdr: begin
                gnt            = sel;
                hzz_mosi       = hdr;
                hzz_mosi_valid = 1'b1;
            end
            StWdat: begin
                gnt            = sel;
                hzz_mosi       = wdata[idx_q*HZZ_DW +: HZZ_DW];
                hzz_mosi_valid = wvalid[idx_q];
                wready         = sel & {NREQ{hzz_mosi_en}};
            end
            StRdat: begin
                gnt    = sel;
                rdata  = hzz_miso;
                rvalid = sel & {NREQ{hzz_miso_valid}};
            end
            StDone: done = sel;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            last_q   <= IW'(NREQ - 1);
            wr_q     <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            stray_rd <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            stray_rd <= stray_d;
        end
    end

endmodule

// File: tb/tb_ddrif_arb.sv
// Randomized scoreboard bench for ddrif_arb: a transaction model predicts grant order and all
// beats; a negedge monitor pops and compares whatever the DUT presents.
module tb_ddrif_arb;

    localparam int unsigned NREQ = 3;
    localparam int unsigned DW   = 64;
    localparam int unsigned AW   = 28;
    localparam int unsigned LW   = 8;

    typedef struct {
        bit            wr;
        logic [LW-1:0] len;
    } txn_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      req_wr;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*LW-1:0]   req_len;
    logic [NREQ-1:0]      gnt;
    logic [NREQ*DW-1:0]   wdata;
    logic [NREQ-1:0]      wvalid;
    logic [NREQ-1:0]      wready;
    logic [DW-1:0]        rdata;
    logic [NREQ-1:0]      rvalid;
    logic [NREQ-1:0]      done;
    logic [DW-1:0]        hzz_mosi;
    logic                 hzz_mosi_valid;
    logic                 hzz_mosi_en;
    logic [DW-1:0]        hzz_miso;
    logic                 hzz_miso_valid;

    ddrif_arb #(
        .NREQ   (NREQ),
        .HZZ_DW (DW),
        .APP_AW (AW),
        .LW     (LW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_len        (req_len),
        .gnt            (gnt),
        .wdata          (wdata),
        .wvalid         (wvalid),
        .wready         (wready),
        .rdata          (rdata),
        .rvalid         (rvalid),
        .done           (done),
        .hzz_mosi       (hzz_mosi),
        .hzz_mosi_valid (hzz_mosi_valid),
        .hzz_mosi_en    (hzz_mosi_en),
        .hzz_miso       (hzz_miso),
        .hzz_miso_valid (hzz_miso_valid)
    );

    initial forever #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Scoreboard and model state
    logic [DW-1:0] exp_mosi[$];
    logic [DW-1:0] exp_rd_dat[$];
    int            exp_rd_idx[$];
    int            exp_done[$];
    txn_t          txn_q[$];
    logic [DW-1:0] wq[NREQ][$];
    logic [DW-1:0] miso_q[$];
    int            m_last = NREQ - 1;
    int            rd_credit = 0;
    int            dd_wleft = 0;
    int            en_mode = 2;
    bit            inject_stray = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic finish_sim();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    endtask

    // Build one batch of requests, predict the full round-robin service order and every beat.
    task automatic issue(input logic [NREQ-1:0] mask, input int wr_sel, input int len_lo,
                         input int len_hi, input bit rand_addr, input logic [AW-1:0] addr);
        bit            wr_a[NREQ];
        logic [LW-1:0] len_a[NREQ];
        logic [AW-1:0] addr_a[NREQ];
        bit            left[NREQ];
        int            nleft;
        int            j;
        int            c;
        txn_t          t;
        logic [DW-1:0] h;
        logic [DW-1:0] d;
        nleft = 0;
        for (int i = 0; i < int'(NREQ); i++) begin
            left[i]   = mask[i];
            wr_a[i]   = 1'b0;
            len_a[i]  = '0;
            addr_a[i] = '0;
            if (mask[i]) begin
                nleft++;
                wr_a[i]   = (wr_sel == 2) ? 1'($urandom_range(1, 0)) : (wr_sel == 1);
                len_a[i]  = LW'($urandom_range(len_hi, len_lo));
                addr_a[i] = rand_addr ? AW'($urandom) : addr;
                req_wr[i] = wr_a[i];
                req_addr[i*AW +: AW] = addr_a[i];
                req_len[i*LW +: LW]  = len_a[i];
            end
        end
        while (nleft > 0) begin
            j = -1;
            for (int k = 1; k <= int'(NREQ); k++) begin
                c = (m_last + k) % int'(NREQ);
                if (j < 0 && left[c]) j = c;
            end
            left[j] = 1'b0;
            nleft--;
            m_last = j;
            h = '0;
            h[DW-1] = wr_a[j];
            h[DW-2 -: LW] = len_a[j];
            h[AW-1:0] = addr_a[j];
            exp_mosi.push_back(h);
            t.wr  = wr_a[j];
            t.len = len_a[j];
            txn_q.push_back(t);
            for (int b = 0; b <= int'(len_a[j]); b++) begin
                d = {$urandom, $urandom};
                if (wr_a[j]) begin
                    wq[j].push_back(d);
                    exp_mosi.push_back(d);
                end else begin
                    miso_q.push_back(d);
                    exp_rd_idx.push_back(j);
                    exp_rd_dat.push_back(d);
                end
            end
            exp_done.push_back(j);
        end
        req = req | mask;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_done.size() != 0 || exp_mosi.size() != 0 || exp_rd_dat.size() != 0)
               && n < 3000) begin
            @(posedge clk);
            n++;
        end
        n_chk++;
        if (n >= 3000) begin
            n_err++;
            $display("FAIL %s timeout: pending done=%0d mosi=%0d rd=%0d, required 0 0 0",
                     name, exp_done.size(), exp_mosi.size(), exp_rd_dat.size());
            finish_sim();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Requesters and ddrif model: react at posedge+1 to what the negedge saw transfer.
    logic [NREQ-1:0] s_gnt;
    logic [NREQ-1:0] s_wfire;
    bit              s_mfire;
    bit              s_rfire;
    bit              stray_now = 1'b0;
    txn_t            dt;

    initial begin
        forever begin
            @(negedge clk);
            s_gnt   = gnt;
            s_wfire = wvalid & wready;
            s_mfire = hzz_mosi_valid && hzz_mosi_en;
            s_rfire = hzz_miso_valid && !stray_now;
            @(posedge clk);
            #1;
            if (rst) begin
                wvalid         = '0;
                hzz_miso_valid = 1'b0;
                stray_now      = 1'b0;
            end else begin
                req = req & ~s_gnt;
                for (int i = 0; i < int'(NREQ); i++) begin
                    if (s_wfire[i] && wq[i].size() > 0) void'(wq[i].pop_front());
                end
                if (s_mfire) begin
                    if (dd_wleft > 0) begin
                        dd_wleft--;
                    end else if (txn_q.size() > 0) begin
                        dt = txn_q.pop_front();
                        if (dt.wr) dd_wleft = int'(dt.len) + 1;
                        else rd_credit += int'(dt.len) + 1;
                    end
                end
                if (s_rfire && miso_q.size() > 0) begin
                    void'(miso_q.pop_front());
                    rd_credit--;
                end
                for (int i = 0; i < int'(NREQ); i++) begin
                    wvalid[i] = (wq[i].size() > 0) && ($urandom_range(3, 0) != 0);
                    wdata[i*DW +: DW] = (wq[i].size() > 0) ? wq[i][0] : '0;
                end
                case (en_mode)
                    0: hzz_mosi_en = ($urandom_range(3, 0) != 0);
                    1: hzz_mosi_en = !hzz_mosi_en;
                    default: hzz_mosi_en = 1'b1;
                endcase
                if (inject_stray) begin
                    inject_stray   = 1'b0;
                    stray_now      = 1'b1;
                    hzz_miso_valid = 1'b1;
                    hzz_miso       = {$urandom, $urandom};
                end else begin
                    stray_now      = 1'b0;
                    hzz_miso_valid = (rd_credit > 0) && (miso_q.size() > 0)
                                     && ($urandom_range(2, 0) != 0);
                    hzz_miso       = hzz_miso_valid ? miso_q[0] : '0;
                end
            end
        end
    end

    // Monitor
    initial begin
        int            e;
        logic [DW-1:0] d;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (hzz_mosi_valid && hzz_mosi_en) begin
                    if (exp_mosi.size() == 0) check("mosi_unexpected", 64'(hzz_mosi_valid), 0);
                    else check("mosi_beat", hzz_mosi, exp_mosi.pop_front());
                end
                if (rvalid != '0) begin
                    if (exp_rd_dat.size() == 0) begin
                        check("rvalid_unexpected", 64'(rvalid), 0);
                    end else begin
                        e = exp_rd_idx.pop_front();
                        d = exp_rd_dat.pop_front();
                        check("rvalid_route", 64'(rvalid), 64'(1) << e);
                        check("rdata", rdata, d);
                    end
                end
                if (done != '0) begin
                    if (exp_done.size() == 0) begin
                        check("done_unexpected", 64'(done), 0);
                    end else begin
                        e = exp_done.pop_front();
                        check("done_route", 64'(done), 64'(1) << e);
                        check("gnt_at_done", 64'(gnt), 0);
                    end
                end
                if (wready != '0) begin
                    check("wready_follows_en", 64'(wready), 64'(gnt & {NREQ{hzz_mosi_en}}));
                end
                if (gnt != '0) check("gnt_onehot", 64'($onehot(gnt)), 1);
            end
        end
    end

    initial begin
        logic [NREQ-1:0] m;
        int              n;
        rst            = 1'b1;
        req            = '0;
        req_wr         = '0;
        req_addr       = '0;
        req_len        = '0;
        wdata          = '0;
        wvalid         = '0;
        hzz_mosi_en    = 1'b0;
        hzz_miso       = '0;
        hzz_miso_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", 64'(gnt), 0);
        check("rst_wready", 64'(wready), 0);
        check("rst_rvalid_done", 64'({rvalid, done}), 0);
        check("rst_mosi_valid", 64'(hzz_mosi_valid), 0);
        check("rst_mosi", hzz_mosi, 0);
        check("rst_rdata", rdata, 0);
        check("rst_stray", 64'(dut.stray_rd), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // All requesters at once, single-beat bursts, twice round the ring
        en_mode = 2;
        issue(3'b111, 2, 0, 0, 1'b1, '0);
        wait_done("grant_order_a");
        issue(3'b111, 2, 0, 0, 1'b1, '0);
        wait_done("grant_order_b");

        issue(3'b001, 0, 3, 3, 1'b0, 28'h100);
        wait_done("read_len3");

        en_mode = 1;
        issue(3'b010, 1, 7, 7, 1'b1, '0);
        wait_done("write_len7_toggle_en");

        en_mode = 0;
        issue(3'b100, 1, 255, 255, 1'b1, '0);
        wait_done("write_len255");

        inject_stray = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("stray_rd_set", 64'(dut.stray_rd), 1);

        for (int r = 0; r < 20; r++) begin
            m       = NREQ'($urandom_range(7, 1));
            en_mode = $urandom_range(2, 0);
            issue(m, 2, 0, 15, 1'b1, '0);
            wait_done("random_batch");
        end

        // Reset in the middle of a write burst after three beats have gone out
        en_mode = 2;
        issue(3'b001, 1, 7, 7, 1'b1, '0);
        n = 0;
        while (wq[0].size() > 5 && n < 500) begin
            @(posedge clk);
            #2;
            n++;
        end
        n_chk++;
        if (n >= 500) begin
            n_err++;
            $display("FAIL reset_mid_wait: beats left %0d, required 5", wq[0].size());
            finish_sim();
        end
        rst = 1'b1;
        #1;
        check("rstmid_gnt_wready", 64'({gnt, wready}), 0);
        check("rstmid_rvalid_done", 64'({rvalid, done}), 0);
        check("rstmid_mosi", {hzz_mosi[DW-2:0], hzz_mosi_valid}, 0);
        check("rstmid_rdata", rdata, 0);
        exp_mosi.delete();
        exp_rd_dat.delete();
        exp_rd_idx.delete();
        exp_done.delete();
        txn_q.delete();
        miso_q.delete();
        for (int i = 0; i < int'(NREQ); i++) wq[i].delete();
        rd_credit = 0;
        dd_wleft  = 0;
        m_last    = NREQ - 1;
        req       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rstmid_stray_clear", 64'(dut.stray_rd), 0);
        issue(3'b011, 2, 0, 3, 1'b1, '0);
        wait_done("after_reset");

        finish_sim();
    end

endmodule
